// File: rtl/scrambler_pkg.sv
// Shared definitions for the parallel 802.11 additive scrambler (x^7+x^4+1).
// Holds the 802.11 defaults, the seed-recovery state type and the single-step LFSR helper.
package scrambler_pkg;

    localparam int         LFSR_W_DEF = 7;
    localparam int         TAP_A_DEF  = 7;
    localparam int         TAP_B_DEF  = 4;
    localparam logic [6:0] SEED_DEF   = 7'h7F;

    // Widest LFSR the helper supports; narrower LFSRs are masked down to their width
    localparam int LFSR_MAX_W = 32;
    localparam int LFSR_IDX_W = $clog2(LFSR_MAX_W);

    typedef enum logic [1:0] {
        REC_IDLE    = 2'd0,
        REC_RECOVER = 2'd1,
        REC_RUN     = 2'd2
    } rec_state_e;

    typedef struct packed {
        logic [LFSR_MAX_W-1:0] next;
        logic                  fb;
    } step_t;

    function automatic step_t lfsr_step(input logic [LFSR_MAX_W-1:0] state,
                                        input int w, input int ta, input int tb);
        step_t                 r;
        logic [LFSR_MAX_W-1:0] m;
        m      = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - w);
        r.fb   = state[LFSR_IDX_W'(ta - 1)] ^ state[LFSR_IDX_W'(tb - 1)];
        r.next = ((state << 1) | {{(LFSR_MAX_W-1){1'b0}}, r.fb}) & m;
        return r;
    endfunction

endpackage

// File: rtl/scrambler_lfsr_unroll.sv
// Combinational DATA_W-step unroll of the scrambler LFSR; bit 0 is first in time.
// Bits flagged in rec_mask are shifted into the LFSR as-is and produce a zero output bit.
module scrambler_lfsr_unroll
    import scrambler_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LFSR_W = LFSR_W_DEF,
    parameter int TAP_A  = TAP_A_DEF,
    parameter int TAP_B  = TAP_B_DEF
) (
    input  logic [LFSR_W-1:0] state,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] rec_mask,
    output logic [LFSR_W-1:0] next_state,
    output logic [DATA_W-1:0] data_out
);

    localparam logic [LFSR_MAX_W-1:0] W_MASK = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - LFSR_W);

    for (genvar k = 0; k < DATA_W; k++) begin : g_bit
        logic [LFSR_MAX_W-1:0] s_in_s;
        logic [LFSR_MAX_W-1:0] s_next_s;
        step_t                 step_s;

        if (k == 0) begin : g_first
            assign s_in_s = LFSR_MAX_W'(state);
        end else begin : g_rest
            assign s_in_s = g_bit[k-1].s_next_s;
        end

        assign step_s   = lfsr_step(s_in_s, LFSR_W, TAP_A, TAP_B);
        // A recovered bit is the scrambler's own feedback bit, so it enters the LFSR directly
        assign s_next_s = rec_mask[k] ? (((s_in_s << 1) | LFSR_MAX_W'(data[k])) & W_MASK)
                                      : step_s.next;
        assign data_out[k] = rec_mask[k] ? 1'b0 : (data[k] ^ step_s.fb);
    end

    assign next_state = g_bit[DATA_W-1].s_next_s[LFSR_W-1:0];

endmodule

// File: rtl/scrambler_par.sv
// Parallel 802.11 scrambler/descrambler with valid/ready stream, seed load and bypass.
// Optional SCRAMBLER_SEED_RECOVERY_EN adds sync_start and recovery of the seed from SERVICE zeros.
module scrambler_par
    import scrambler_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                LFSR_W       = LFSR_W_DEF,
    parameter int                TAP_A        = TAP_A_DEF,
    parameter int                TAP_B        = TAP_B_DEF,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(SEED_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              bypass,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LFSR_W-1:0] state_out
`ifdef SCRAMBLER_SEED_RECOVERY_EN
    ,
    input  logic              sync_start
`endif
);

    logic [LFSR_W-1:0] lfsr_r;
    logic [LFSR_W-1:0] lfsr_nxt_s;
    logic [LFSR_W-1:0] base_state_s;
    logic [LFSR_W-1:0] unroll_state_s;
    logic [DATA_W-1:0] unroll_data_s;
    logic [DATA_W-1:0] beat_data_s;
    logic [DATA_W-1:0] rec_mask_s;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              accept_s;
    logic              load_s;

    assign in_ready  = !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign state_out = lfsr_r;

`ifdef SCRAMBLER_SEED_RECOVERY_EN
    localparam int CNT_W = $clog2(LFSR_W + 1);

    rec_state_e       rec_state_r;
    rec_state_e       rec_state_nxt_s;
    logic [CNT_W-1:0] rec_cnt_r;
    logic [CNT_W-1:0] rec_cnt_nxt_s;
    logic [CNT_W-1:0] rec_base_s;
    logic             rec_active_s;

    // sync_start restarts recovery in the same cycle, so its beat is already captured
    assign load_s       = seed_load && !sync_start;
    assign rec_active_s = sync_start || (rec_state_r == REC_RECOVER);
    assign rec_base_s   = sync_start ? {CNT_W{1'b0}} : rec_cnt_r;

    for (genvar k = 0; k < DATA_W; k++) begin : g_mask
        assign rec_mask_s[k] = rec_active_s && ((int'(rec_base_s) + k) < LFSR_W);
    end

    // Recovery FSM next state: captured-bit count decides when RUN starts
    always_comb begin
        rec_state_nxt_s = rec_state_r;
        rec_cnt_nxt_s   = rec_cnt_r;
        if (rec_active_s && accept_s && !bypass) begin
            if ((int'(rec_base_s) + DATA_W) >= LFSR_W) begin
                rec_state_nxt_s = REC_RUN;
                rec_cnt_nxt_s   = CNT_W'(LFSR_W);
            end else begin
                rec_state_nxt_s = REC_RECOVER;
                rec_cnt_nxt_s   = CNT_W'(int'(rec_base_s) + DATA_W);
            end
        end else if (sync_start) begin
            rec_state_nxt_s = REC_RECOVER;
            rec_cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (!(rec_state_r inside {REC_IDLE, REC_RECOVER, REC_RUN})) begin
            rec_state_nxt_s = REC_IDLE;
            rec_cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
            rec_state_nxt_s = rec_state_r;
        end
    end

    // Recovery FSM state and captured-bit counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rec_state_r <= REC_IDLE;
            rec_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            rec_state_r <= rec_state_nxt_s;
            rec_cnt_r   <= rec_cnt_nxt_s;
        end
    end
`else
    assign load_s     = seed_load;
    assign rec_mask_s = {DATA_W{1'b0}};
`endif

    scrambler_lfsr_unroll #(
        .DATA_W (DATA_W),
        .LFSR_W (LFSR_W),
        .TAP_A  (TAP_A),
        .TAP_B  (TAP_B)
    ) u_unroll (
        .state      (base_state_s),
        .data       (in_data),
        .rec_mask   (rec_mask_s),
        .next_state (unroll_state_s),
        .data_out   (unroll_data_s)
    );

    // Seed mux ahead of the unroll so a load and an accept in one cycle use the new seed
    always_comb begin
        if (load_s) begin
            base_state_s = (seed == {LFSR_W{1'b0}}) ? SEED_DEFAULT : seed;
        end else begin
            base_state_s = lfsr_r;
        end
        if (accept_s && !bypass) begin
            lfsr_nxt_s = unroll_state_s;
        end else begin
            lfsr_nxt_s = base_state_s;
        end
        if (bypass) begin
            beat_data_s = in_data;
        end else begin
            beat_data_s = unroll_data_s;
        end
    end

    // LFSR state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_r <= SEED_DEFAULT;
        end else begin
            lfsr_r <= lfsr_nxt_s;
        end
    end

    // Output stage: load on accept, hold while stalled, drop valid once drained
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= beat_data_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_scrambler_par.sv
// Self-checking bench for scrambler_par: PN-sequence reference model, scoreboard and directed cases.
// Covers the SCRAMBLER_SEED_RECOVERY_EN feature when that macro is defined.
module tb_scrambler_par;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // Main instance (8-bit), model-checked every cycle
    logic       tx_seed_load, tx_bypass, tx_in_valid, tx_in_ready, tx_out_valid, tx_out_ready;
    logic [6:0] tx_seed, tx_state;
    logic [7:0] tx_in_data, tx_out_data;
    // Descrambler instance (8-bit)
    logic       rx_seed_load, rx_bypass, rx_in_valid, rx_in_ready, rx_out_valid, rx_out_ready;
    logic [6:0] rx_seed, rx_state;
    logic [7:0] rx_in_data, rx_out_data;
    // Serial instance (1-bit)
    logic       bit_seed_load, bit_bypass, bit_in_valid, bit_in_ready, bit_out_valid, bit_out_ready;
    logic [6:0] bit_seed, bit_state;
    logic [0:0] bit_in_data, bit_out_data;
`ifdef SCRAMBLER_SEED_RECOVERY_EN
    logic tx_sync = 1'b0, rx_sync = 1'b0, bit_sync = 1'b0;
`endif

    scrambler_par #(.DATA_W(8)) u_tx (
        .clock(clock), .reset(reset), .seed_load(tx_seed_load), .seed(tx_seed), .bypass(tx_bypass),
        .in_valid(tx_in_valid), .in_ready(tx_in_ready), .in_data(tx_in_data),
        .out_valid(tx_out_valid), .out_ready(tx_out_ready), .out_data(tx_out_data), .state_out(tx_state)
`ifdef SCRAMBLER_SEED_RECOVERY_EN
        , .sync_start(tx_sync)
`endif
    );

    scrambler_par #(.DATA_W(8)) u_rx (
        .clock(clock), .reset(reset), .seed_load(rx_seed_load), .seed(rx_seed), .bypass(rx_bypass),
        .in_valid(rx_in_valid), .in_ready(rx_in_ready), .in_data(rx_in_data),
        .out_valid(rx_out_valid), .out_ready(rx_out_ready), .out_data(rx_out_data), .state_out(rx_state)
`ifdef SCRAMBLER_SEED_RECOVERY_EN
        , .sync_start(rx_sync)
`endif
    );

    scrambler_par #(.DATA_W(1)) u_bit (
        .clock(clock), .reset(reset), .seed_load(bit_seed_load), .seed(bit_seed), .bypass(bit_bypass),
        .in_valid(bit_in_valid), .in_ready(bit_in_ready), .in_data(bit_in_data),
        .out_valid(bit_out_valid), .out_ready(bit_out_ready), .out_data(bit_out_data), .state_out(bit_state)
`ifdef SCRAMBLER_SEED_RECOVERY_EN
        , .sync_start(bit_sync)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference: the 127-bit PN sequence and the LFSR state before each of its bits
    logic       pn [0:126];
    logic [6:0] st [0:126];
    int         m_pos = 0;
    logic [7:0] exp_q [$];

    logic [7:0] orig [0:19];
    logic [7:0] txd  [0:19];
    logic       first_bit;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pos_of(input logic [6:0] sd);
        if (sd == 7'h00) return 0;
        for (int i = 0; i < 127; i++) begin
            if (st[i] == sd) return i;
        end
        return 0;
    endfunction

    task automatic model_beat(input logic [7:0] d, input logic byp, output logic [7:0] r);
        r = d;
        if (!byp) begin
            for (int k = 0; k < 8; k++) r[k] = d[k] ^ pn[(m_pos + k) % 127];
            m_pos = (m_pos + 8) % 127;
        end
    endtask

    // Compare the main instance against the model, then advance the model by this cycle's events
    task automatic tx_model_step();
        logic       mv;
        logic       acc;
        logic [7:0] r;
        mv = (exp_q.size() != 0);
        chk("tx_out_valid", 64'(tx_out_valid), 64'(mv));
        if (mv) chk("tx_out_data", 64'(tx_out_data), 64'(exp_q[0]));
        chk("tx_in_ready", 64'(tx_in_ready), 64'(!mv || tx_out_ready));
        chk("tx_state", 64'(tx_state), 64'(st[m_pos]));
        acc = tx_in_valid && (!mv || tx_out_ready);
        if (mv && tx_out_ready) void'(exp_q.pop_front());
        if (tx_seed_load) m_pos = pos_of(tx_seed);
        if (acc) begin
            model_beat(tx_in_data, tx_bypass, r);
            exp_q.push_back(r);
        end
    endtask

    task automatic cycle();
        @(negedge clock);
        tx_model_step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [6:0] s;
        s = 7'h7F;
        for (int i = 0; i < 127; i++) begin
            st[i] = s;
            pn[i] = s[6] ^ s[3];
            s     = {s[5:0], pn[i]};
        end

        tx_seed_load = 1'b0; tx_seed = 7'h00; tx_bypass = 1'b0; tx_in_valid = 1'b0;
        tx_in_data = 8'h00; tx_out_ready = 1'b1;
        rx_seed_load = 1'b0; rx_seed = 7'h00; rx_bypass = 1'b0; rx_in_valid = 1'b0;
        rx_in_data = 8'h00; rx_out_ready = 1'b1;
        bit_seed_load = 1'b0; bit_seed = 7'h00; bit_bypass = 1'b0; bit_in_valid = 1'b0;
        bit_in_data = 1'b0; bit_out_ready = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(tx_out_valid), 64'(1'b0));
        chk("rst_out_data", 64'(tx_out_data), 64'(8'h00));
        chk("rst_state", 64'(tx_state), 64'(7'h7F));
        chk("rst_bit_state", 64'(bit_state), 64'(7'h7F));
        reset = 1'b1;

        // 802.11 sequence from the default seed
        tx_in_valid = 1'b1; tx_in_data = 8'h00;
        cycle();
        chk("seq_byte0", 64'(tx_out_data), 64'(8'h70));
        cycle();
        chk("seq_byte1", 64'(tx_out_data), 64'(8'h4F));

        // Zero seed loaded with an accept falls back to 7'h7F and the beat uses it
        tx_seed_load = 1'b1; tx_seed = 7'h00; tx_in_data = 8'h00;
        cycle();
        chk("zero_seed_beat", 64'(tx_out_data), 64'(8'h70));
        chk("zero_seed_state", 64'(tx_state), 64'(7'h0E));
        tx_seed_load = 1'b0;

        // Backpressure: in_ready low and output held for 5 cycles
        tx_out_ready = 1'b0; tx_in_data = 8'hA5;
        cycle();
        for (int i = 0; i < 5; i++) begin
            tx_in_data = 8'($urandom);
            cycle();
            chk("hold_in_ready", 64'(tx_in_ready), 64'(1'b0));
        end
        tx_out_ready = 1'b1;
        tx_in_valid  = 1'b0;
        cycle();
        cycle();

        // Randomised traffic, loads (some zero) and bypass
        for (int i = 0; i < 400; i++) begin
            tx_in_valid  = ($urandom_range(0, 9) < 7);
            tx_out_ready = ($urandom_range(0, 9) < 7);
            tx_bypass    = ($urandom_range(0, 4) == 0);
            tx_seed_load = ($urandom_range(0, 19) == 0);
            tx_seed      = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
            tx_in_data   = 8'($urandom);
            cycle();
        end
        tx_bypass = 1'b0; tx_seed_load = 1'b0;

        // Asynchronous reset drops a held beat immediately
        tx_in_valid = 1'b1; tx_out_ready = 1'b0;
        cycle();
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", 64'(tx_out_valid), 64'(1'b0));
        chk("async_rst_data", 64'(tx_out_data), 64'(8'h00));
        chk("async_rst_state", 64'(tx_state), 64'(7'h7F));
        exp_q.delete();
        m_pos = 0;
        tx_in_valid = 1'b0; tx_out_ready = 1'b1;
        #1 reset = 1'b1;
        cycle();

        // Scramble with 7'h5D, then descramble with a second instance
        for (int i = 0; i < 20; i++) orig[i] = 8'($urandom);
        tx_seed = 7'h5D;
        for (int i = 0; i < 20; i++) begin
            tx_in_valid = 1'b1; tx_seed_load = (i == 0); tx_in_data = orig[i];
            cycle();
            txd[i] = tx_out_data;
        end
        tx_in_valid = 1'b0; tx_seed_load = 1'b0;
        rx_seed = 7'h5D;
        for (int i = 0; i < 20; i++) begin
            rx_in_valid = 1'b1; rx_seed_load = (i == 0); rx_in_data = txd[i];
            cycle();
            chk("rx_in_ready", 64'(rx_in_ready), 64'(1'b1));
            chk("rx_out_valid", 64'(rx_out_valid), 64'(1'b1));
            chk("rx_descrambled", 64'(rx_out_data), 64'(orig[i]));
        end
        rx_in_valid = 1'b0; rx_seed_load = 1'b0;
        chk("rx_state", 64'(rx_state), 64'(st[(pos_of(7'h5D) + 160) % 127]));

        // Serial instance: period of 127 steps
        bit_in_valid = 1'b1; bit_in_data = 1'b0;
        for (int i = 0; i < 128; i++) begin
            cycle();
            if (i == 0) first_bit = bit_out_data[0];
            chk("bit_valid", 64'(bit_out_valid), 64'(1'b1));
            chk("bit_pn", 64'(bit_out_data), 64'(pn[i % 127]));
            if (i == 126) chk("bit_period_state", 64'(bit_state), 64'(7'h7F));
            chk("bit_in_ready", 64'(bit_in_ready), 64'(1'b1));
        end
        chk("bit128_eq_bit1", 64'(bit_out_data), 64'(first_bit));
        bit_in_valid = 1'b0;

`ifdef SCRAMBLER_SEED_RECOVERY_EN
        // Seed recovery from scrambled SERVICE zeros seeded with 7'h2A
        orig[0] = 8'h00; orig[1] = 8'h00;
        for (int i = 2; i < 8; i++) orig[i] = 8'($urandom);
        tx_seed = 7'h2A;
        for (int i = 0; i < 8; i++) begin
            tx_in_valid = 1'b1; tx_seed_load = (i == 0); tx_in_data = orig[i];
            cycle();
            txd[i] = tx_out_data;
        end
        tx_in_valid = 1'b0; tx_seed_load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx_in_valid = 1'b1; rx_sync = (i == 0); rx_in_data = txd[i];
            rx_seed_load = (i == 0); rx_seed = 7'h11;
            cycle();
            chk("rec_out", 64'(rx_out_data), 64'(orig[i]));
            if (i == 0) chk("rec_state", 64'(rx_state), 64'(st[(pos_of(7'h2A) + 8) % 127]));
        end
        rx_in_valid = 1'b0; rx_sync = 1'b0; rx_seed_load = 1'b0;
`endif

        cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
